// File: rtl/input_spi.sv
// Serial frame receiver: each data bit is sent as marker(1), data, stop(0),
// LSB first, while en_in is held low. Delivers a byte with a one-cycle valid
// pulse, or a one-cycle err pulse on a framing error or an aborted frame.
module input_spi #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in,
  input  logic            en_in,
  output logic [BITS-1:0] out,
  output logic            valid,
  output logic            err,
  output logic            busy
);

  localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic [BITS-1:0] sr_q, sr_d;
  logic [BITS-1:0] out_q, out_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;

  // Next-state and output decode; en_in abort takes priority over the line.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!en_in && in) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      MARK: begin
        if (en_in || !in) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (en_in) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          sr_d[bitcnt_q] = in;
          state_d        = STOP;
        end
      end
      STOP: begin
        if (en_in || in) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (bitcnt_q == LAST_BIT) begin
          state_d = IDLE;
          out_d   = sr_q;
          valid_d = 1'b1;
        end else begin
          state_d  = MARK;
          bitcnt_d = bitcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule
